// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the PC fetch interface: one outstanding request,
// fixed response latency, alignment/range checking and a side load port.
module imem_fetch_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned AW        = 12,
    parameter int unsigned LATENCY   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_pc,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_instr,
    output logic [31:0]   resp_pc,
    output logic [1:0]    resp_err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_idx,
    input  logic [31:0]   ld_data
);

    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pc_q, pc_d;
    logic [1:0]    err_q, err_d;

    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   offset;
    logic [AW-1:0] rd_idx;
    logic          err_align;
    logic          err_range;

    // Out-of-range offsets wrap; the resulting index is harmless because the word is masked.
    assign offset    = req_pc - BASE_ADDR;
    assign rd_idx    = AW'(offset >> 2);
    assign err_align = |req_pc[1:0];
    assign err_range = ({1'b0, req_pc} < {1'b0, BASE_ADDR}) || ({1'b0, req_pc} >= LIMIT);

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_instr = instr_q;
    assign resp_pc    = pc_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    pc_d    = req_pc;
                    err_d   = {err_range, err_align};
                    instr_d = (err_range || err_align) ? '0 : mem_q[rd_idx];
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
            pc_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    // Same-edge accept reads the pre-write contents, giving read-before-write.
    always_ff @(posedge clk) begin
        if (ld_en && !rst) begin
            mem_q[ld_idx] <= ld_data;
        end
    end

endmodule
